// File: rtl/rs_adder_station_pkg.sv
// Opcodes, tag constants and the per-entry control record shared by the adder reservation station.
// Build option RS_OLDEST_FIRST_EN adds an age field to each entry for oldest-first dispatch.
package rs_pkg;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SUB  = 4'b0001;
   localparam logic [3:0] OP_ADDI = 4'b0100;
   localparam logic [3:0] OP_SUBI = 4'b0101;

   localparam int TAG_NONE = 0;

   // Age is a rank among busy entries, so 3 bits cover DEPTH up to 8.
   localparam int AGE_W = 3;

   typedef struct packed {
      logic       busy;
      logic [3:0] op;
`ifdef RS_OLDEST_FIRST_EN
      logic [AGE_W-1:0] age;
`endif
   } rs_entry_t;

endpackage

// File: rtl/rs_adder_station_if.sv
// Issue, CDB and dispatch signals of the adder reservation station.
// master = issue logic / CDB / adder side, slave = the station itself.
interface rs_adder_station_if #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 16,
   parameter int TAG_W  = 3
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              issue_valid;
   logic              issue_ready;
   logic [3:0]        issue_op;
   logic [DATA_W-1:0] issue_vj;
   logic [DATA_W-1:0] issue_vk;
   logic [TAG_W-1:0]  issue_qj;
   logic [TAG_W-1:0]  issue_qk;
   logic [TAG_W-1:0]  issue_tag;

   logic              cdb_valid;
   logic [TAG_W-1:0]  cdb_tag;
   logic [DATA_W-1:0] cdb_data;

   logic              disp_valid;
   logic              disp_ready;
   logic [3:0]        disp_op;
   logic [DATA_W-1:0] disp_a;
   logic [DATA_W-1:0] disp_b;
   logic [TAG_W-1:0]  disp_tag;

   logic [CNT_W-1:0]  free_count;

   modport master (
      output issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
      output cdb_valid, cdb_tag, cdb_data, disp_ready,
      input  issue_ready, issue_tag, disp_valid, disp_op, disp_a, disp_b, disp_tag, free_count
   );

   modport slave (
      input  issue_valid, issue_op, issue_vj, issue_vk, issue_qj, issue_qk,
      input  cdb_valid, cdb_tag, cdb_data, disp_ready,
      output issue_ready, issue_tag, disp_valid, disp_op, disp_a, disp_b, disp_tag, free_count
   );

endinterface

// File: rtl/rs_adder_station_select.sv
// Combinational picker: the ready entry with the largest age wins, ties go to the lowest index.
// With all ages tied at zero this degenerates to a plain lowest-index priority picker.
module rs_select #(
   parameter int DEPTH = 4,
   parameter int AGE_W = 3,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0]       ready,
   input  logic [DEPTH*AGE_W-1:0] age,
   output logic [IDX_W-1:0]       idx,
   output logic                   found
);

   logic [AGE_W-1:0] best_age;

   always_comb begin
      found    = 1'b0;
      idx      = '0;
      best_age = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (ready[i] && (!found || (age[i*AGE_W +: AGE_W] > best_age))) begin
            found    = 1'b1;
            idx      = IDX_W'(i);
            best_age = age[i*AGE_W +: AGE_W];
         end
      end
   end

endmodule

// File: rtl/rs_adder_station.sv
// Reservation station for the adder unit: holds issued add/sub ops, snoops the CDB, dispatches ready ops.
// Define RS_OLDEST_FIRST_EN to dispatch the oldest ready entry instead of the lowest-index one.
module rs_adder_station
   import rs_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int DATA_W   = 16,
   parameter int TAG_W    = 3,
   parameter int TAG_BASE = 1
) (
   input logic               Clock,
   input logic               Reset,
   rs_adder_station_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [TAG_W-1:0] QNONE = TAG_W'(TAG_NONE);

   logic [3:0]        op_cur [DEPTH];
   logic [DATA_W-1:0] vj_cur [DEPTH];
   logic [DATA_W-1:0] vk_cur [DEPTH];
   logic [DEPTH-1:0]  free_vec;
   logic [DEPTH-1:0]  ready_vec;
   logic [DEPTH*AGE_W-1:0] age_vec;

   logic [IDX_W-1:0]  alloc_idx;
   logic [IDX_W-1:0]  pick_idx;
   logic [IDX_W-1:0]  sel_idx;
   logic [IDX_W-1:0]  hold_idx_reg;
   logic              alloc_found;
   logic              pick_found;
   logic              hold_reg;
   logic              do_issue;
   logic              do_disp;
   logic [CNT_W-1:0]  free_cnt;

   logic              byp_j;
   logic              byp_k;
   logic [DATA_W-1:0] new_vj;
   logic [DATA_W-1:0] new_vk;
   logic [TAG_W-1:0]  new_qj;
   logic [TAG_W-1:0]  new_qk;

   // A result appearing on the CDB in the issue cycle is captured directly at allocation.
   assign byp_j  = bus.cdb_valid && (bus.issue_qj != QNONE) && (bus.issue_qj == bus.cdb_tag);
   assign byp_k  = bus.cdb_valid && (bus.issue_qk != QNONE) && (bus.issue_qk == bus.cdb_tag);
   assign new_vj = byp_j ? bus.cdb_data : bus.issue_vj;
   assign new_vk = byp_k ? bus.cdb_data : bus.issue_vk;
   assign new_qj = byp_j ? QNONE : bus.issue_qj;
   assign new_qk = byp_k ? QNONE : bus.issue_qk;

   always_comb begin
      alloc_found = 1'b0;
      alloc_idx   = '0;
      free_cnt    = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (free_vec[i]) begin
            alloc_found = 1'b1;
            alloc_idx   = IDX_W'(i);
         end
         free_cnt = free_cnt + CNT_W'(free_vec[i]);
      end
   end

   rs_select #(
      .DEPTH (DEPTH),
      .AGE_W (AGE_W),
      .IDX_W (IDX_W)
   ) u_select (
      .ready (ready_vec),
      .age   (age_vec),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // A stalled presentation is pinned so a newly ready entry cannot overtake it.
   assign sel_idx  = hold_reg ? hold_idx_reg : pick_idx;
   assign do_issue = bus.issue_valid && alloc_found;
   assign do_disp  = pick_found && bus.disp_ready;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         hold_reg     <= 1'b0;
         hold_idx_reg <= '0;
      end else begin
         hold_reg     <= pick_found && !bus.disp_ready;
         hold_idx_reg <= sel_idx;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         rs_entry_t         ent_reg;
         logic [DATA_W-1:0] vj_reg;
         logic [DATA_W-1:0] vk_reg;
         logic [TAG_W-1:0]  qj_reg;
         logic [TAG_W-1:0]  qk_reg;
         logic              alloc_here;
         logic              disp_here;
         logic              snoop_j;
         logic              snoop_k;

         assign alloc_here = do_issue && (alloc_idx == IDX_W'(gi));
         assign disp_here  = do_disp && (sel_idx == IDX_W'(gi));
         assign snoop_j    = bus.cdb_valid && ent_reg.busy && (qj_reg != QNONE) && (qj_reg == bus.cdb_tag);
         assign snoop_k    = bus.cdb_valid && ent_reg.busy && (qk_reg != QNONE) && (qk_reg == bus.cdb_tag);

         assign op_cur[gi]    = ent_reg.op;
         assign vj_cur[gi]    = vj_reg;
         assign vk_cur[gi]    = vk_reg;
         assign free_vec[gi]  = !ent_reg.busy;
         assign ready_vec[gi] = ent_reg.busy && (qj_reg == QNONE) && (qk_reg == QNONE);

`ifdef RS_OLDEST_FIRST_EN
         // Age is the count of younger busy entries; entries older than a departing one close the gap.
         logic age_inc;
         logic age_dec;
         assign age_inc = do_issue && !alloc_here;
         assign age_dec = do_disp && !disp_here && (ent_reg.age > age_vec[sel_idx*AGE_W +: AGE_W]);
         assign age_vec[gi*AGE_W +: AGE_W] = ent_reg.age;
`endif

         always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
               ent_reg <= '0;
               vj_reg  <= '0;
               vk_reg  <= '0;
               qj_reg  <= QNONE;
               qk_reg  <= QNONE;
            end else if (alloc_here) begin
               ent_reg.busy <= 1'b1;
               ent_reg.op   <= bus.issue_op;
`ifdef RS_OLDEST_FIRST_EN
               ent_reg.age  <= '0;
`endif
               vj_reg <= new_vj;
               vk_reg <= new_vk;
               qj_reg <= new_qj;
               qk_reg <= new_qk;
            end else begin
               if (disp_here) begin
                  ent_reg.busy <= 1'b0;
               end
               if (snoop_j) begin
                  vj_reg <= bus.cdb_data;
                  qj_reg <= QNONE;
               end
               if (snoop_k) begin
                  vk_reg <= bus.cdb_data;
                  qk_reg <= QNONE;
               end
`ifdef RS_OLDEST_FIRST_EN
               if (ent_reg.busy) begin
                  ent_reg.age <= ent_reg.age + AGE_W'(age_inc) - AGE_W'(age_dec);
               end
`endif
            end
         end
      end
   endgenerate

`ifndef RS_OLDEST_FIRST_EN
   assign age_vec = '0;
`endif

   assign bus.issue_ready = alloc_found;
   assign bus.issue_tag   = TAG_W'(TAG_BASE) + TAG_W'(alloc_idx);
   assign bus.free_count  = free_cnt;
   assign bus.disp_valid  = pick_found;
   assign bus.disp_op     = pick_found ? op_cur[sel_idx] : 4'd0;
   assign bus.disp_a      = pick_found ? vj_cur[sel_idx] : '0;
   assign bus.disp_b      = pick_found ? vk_cur[sel_idx] : '0;
   assign bus.disp_tag    = pick_found ? (TAG_W'(TAG_BASE) + TAG_W'(sel_idx)) : QNONE;

endmodule

// File: doc/rs_adder_station.md
# rs_adder_station

Parametrised reservation station for the adder functional unit in the Tomasulo core. It holds up to DEPTH issued add/sub instructions. Each entry waits for its source operands by snooping the common data bus (CDB), then dispatches ready entries to the adder unit over a valid/ready handshake. Register renaming stays outside: the issue logic supplies operand values or producer tags, and records the tag this station returns.

## Interface
- DEPTH, 4: number of entries, 2..8
- DATA_W, 16: operand/result width
- TAG_W, 3: producer tag width; tag 0 means "value present"
- TAG_BASE, 1: tag of entry 0; entry k owns tag TAG_BASE+k; TAG_BASE+DEPTH-1 must be < 2^TAG_W and TAG_BASE ≥ 1

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high
- issue_valid  in  1  issue request
- issue_ready  out  1  at least one free entry
- issue_op  in  4  opcode (rs_pkg encodings)
- issue_vj, issue_vk  in  DATA_W  operand values, used when the matching q is 0
- issue_qj, issue_qk  in  TAG_W  producer tags; 0 = value valid
- issue_tag  out  TAG_W  tag of the entry that will be allocated; valid while issue_ready
- cdb_valid  in  1  broadcast valid
- cdb_tag  in  TAG_W  producing tag
- cdb_data  in  DATA_W  result
- disp_valid  out  1  a ready entry is presented
- disp_ready  in  1  adder unit accepts
- disp_op  out  4  opcode
- disp_a, disp_b  out  DATA_W  Vj, Vk
- disp_tag  out  TAG_W  entry tag, which the adder unit returns on the CDB
- free_count  out  $clog2(DEPTH)+1  number of free entries

## Operation
- Per-entry state: busy, op, Vj, Qj, Vk, Qk, age.
- Allocation: when issue_valid && issue_ready, the lowest-index free entry is written. issue_tag is driven combinationally from that entry's index.
- Issue bypass: if cdb_valid and cdb_tag equals issue_qj (nonzero), the entry stores Vj=cdb_data and Qj=0. The same rule applies to k.
- Snoop: every busy entry with Qx == cdb_tag (nonzero) captures cdb_data into Vx and clears Qx on the cdb_valid edge. All matching entries capture in the same cycle.
- Ready: busy && Qj==0 && Qk==0.
- Select: among ready entries, one is presented on disp_*. disp_valid = any ready entry.
- Selection is combinational from entry state and must stay stable while disp_valid && !disp_ready. No new entry may overtake a presented entry until it is accepted.
- Free: on disp_valid && disp_ready, the presented entry's busy flag clears at that edge.
- Unknown opcodes are stored and dispatched unchanged; this block does not decode them.
- A CDB tag that no entry is waiting on is ignored.

## Timing
- Reset values: all busy=0, Q=0, age=0. Outputs: issue_ready=1, issue_tag=TAG_BASE, disp_valid=0, disp_*=0, free_count=DEPTH.
- Issue to disp_valid: 1 cycle minimum, when both operands are present or bypassed at issue.
- CDB capture to disp_valid: 1 cycle.
- A freed entry is reallocatable in the cycle after the dispatch handshake, never in the same cycle. issue_ready and free_count are computed from registered busy bits.
- Full: issue_ready=0; issue_valid is ignored and no state changes.
- Issue + dispatch + CDB in the same cycle are all honoured independently.
- Reset asserted mid-operation clears all entries immediately. In-flight instructions are lost; the pipeline flush is the caller's responsibility.

## Configuration
- RS_OLDEST_FIRST_EN defined:
  - Each allocation sets the new entry's age to 0 and increments the age of every other busy entry.
  - The selector picks the ready entry with the largest age.
- Undefined: the age field is absent and the selector picks the lowest-index ready entry.
- All other behaviour is identical in both builds.

## Structure
- rs_pkg holds:
  - opcodes OP_ADD=4'b0000, OP_SUB=4'b0001, OP_ADDI=4'b0100, OP_SUBI=4'b0101
  - TAG_NONE=0
  - the entry struct typedef
- Sub-module rs_select: a purely combinational picker. Inputs are the ready vector and the age vector; outputs are an index and a found flag.

## Test plan
- Reset then issue ADD with qj=0, qk=0, vj=5, vk=7 → next cycle disp_valid=1, disp_a=5, disp_b=7, disp_tag=1. With disp_ready=1 → free_count returns to 4.
- Issue with qj=3, then cdb_valid, tag=3, data=0x1234 two cycles later → disp_valid stays 0 until the cycle after the CDB, then disp_a=0x1234.
- Issue with qk=2 while cdb_valid, tag=2, data=0x00FF in the same cycle → bypass; disp_valid=1 next cycle with disp_b=0x00FF.
- Fill all 4 entries → issue_ready=0 and a 5th issue_valid changes nothing. One handshake → issue_ready=1 next cycle and issue_tag equals the freed entry's tag.
- Ready entries 2 and 0, with entry 2 issued first:
  - with RS_OLDEST_FIRST_EN → disp_tag=3 first
  - without → disp_tag=1 first
- Hold disp_ready=0 for 3 cycles while another entry becomes ready → disp_* unchanged. Assert Reset mid-hold → disp_valid=0 and free_count=4 immediately.
